alu8_exec_stage: RTL

- Registered execution stage for the 8-bit ALU.
- Accepts operand pairs and an opcode over a valid/ready handshake, evaluates them in a combinational core (bitwise logic, add/sub, shifts), and presents result plus flags over a valid/ready output.
- Two-register pipeline, full throughput, with backpressure. Sits between the operand source (register file/test driver) and the result consumer (display/writeback).

---
 rtl/alu8_pkg.sv | 16 +
 rtl/alu8_core.sv | 49 ++++
 rtl/alu8_exec_stage.sv | 69 ++++++
 3 files changed

// File: rtl/alu8_pkg.sv
// alu8_pkg: opcodes, flag bit positions and default width shared by the ALU stage
package alu8_pkg;
  localparam int WIDTH = 8;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu8_core.sv
// alu8_core: combinational ALU producing result and {Z,C,N,V} flags
module alu8_core import alu8_pkg::*; #(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);
  logic [W:0] sum, dif;
  logic c, v;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    res = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_ADD: begin
        res = sum[W-1:0];
        c = sum[W];
        v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res = dif[W-1:0];
        c = dif[W];
        v = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
      end
      OP_SHL: begin
        res = {a[W-2:0], 1'b0};
        c = a[W-1];
      end
      default: begin
        res = {1'b0, a[W-1:1]};
        c = a[0];
      end
    endcase
    flags = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = c;
    flags[FLAG_N] = res[W-1];
    flags[FLAG_V] = v;
  end
endmodule

// File: rtl/alu8_exec_stage.sv
// alu8_exec_stage: two-register valid/ready pipeline around alu8_core
// with a completed-operation counter.
module alu8_exec_stage import alu8_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] op_count
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d, core_res;
  logic [3:0]       s2_flags_q, s2_flags_d, core_flags;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             s1_adv, s2_adv;
  alu8_core #(.W(WIDTH)) u_core (
    .a(s1_a_q), .b(s1_b_q), .op(s1_op_q), .res(core_res), .flags(core_flags)
  );
  // Each stage advances when it is empty or the stage after it is moving.
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_a_d = (s1_adv && in_valid) ? in_a : s1_a_q;
    s1_b_d = (s1_adv && in_valid) ? in_b : s1_b_q;
    s1_op_d = (s1_adv && in_valid) ? in_op : s1_op_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_res_d = (s2_adv && s1_valid_q) ? core_res : s2_res_q;
    s2_flags_d = (s2_adv && s1_valid_q) ? core_flags : s2_flags_q;
    op_count_d = op_count_q + CNT_W'(s2_valid_q && out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_op_q <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q <= '0;
      s2_flags_q <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      s1_op_q <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      op_count_q <= op_count_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign out_res = s2_res_q;
  assign out_flags = s2_flags_q;
  assign op_count = op_count_q;
endmodule
